// File: rtl/axi_slave_package.sv
// Shared AXI slave definitions.
// Holds the AXI ID width, the AXI response code enum, the packed word that
// travels through the write-response FIFO, and the B-channel FSM state type.
package axi_slave_package;

  localparam int ID_WIDTH = 4;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } Resp_t;

  // One buffered write response: ID in the upper bits, response code below.
  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    Resp_t               resp;
  } b_resp_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } b_state_t;

endpackage

// File: rtl/axi_slave_resp_fifo.sv
// Generic synchronous FIFO for internal response words.
// Ports:
//   clk, rst      : clock and synchronous active-high reset
//   push, wdata   : write strobe and word; dropped when full without a same-cycle pop
//   pop, rdata    : read strobe and head word (rdata is the current head, valid when !empty)
//   full, empty   : derived from the pointers only
//   overflow      : sticky flag, set the cycle after a push was dropped, cleared by reset
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module axi_slave_resp_fifo #(
  parameter int  DEPTH  = 8,
  parameter type word_t = logic [7:0]
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  word_t wdata,
  input  logic  pop,
  output word_t rdata,
  output logic  full,
  output logic  empty,
  output logic  overflow
);

  localparam int             AW      = $clog2(DEPTH);
  localparam logic [AW:0]    PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic        overflow_r;
  word_t       mem_r [DEPTH];
  logic        pop_ok_s;
  logic        push_ok_s;

  assign empty = (wr_ptr_r == rd_ptr_r);
  assign full  = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);

  // A pop frees the slot in the same cycle, so a push at full with a pop is accepted.
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);

  assign rdata    = mem_r[rd_ptr_r[AW-1:0]];
  assign overflow = overflow_r;

  // Pointer and sticky overflow state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r   <= {(AW+1){1'b0}};
      rd_ptr_r   <= {(AW+1){1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (push && !push_ok_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/axi_slave_b_resp_channel.sv
// AXI4 write-response (B) channel driver.
// Buffers one-cycle internal response pulses in a FIFO and presents them on
// the B channel with a full BVALID/BREADY handshake, in arrival order.
// Ports:
//   ACLK, ARESET                   : clock, synchronous active-high reset
//   int_BID, int_BRESP, int_BVALID : internal push (no backpressure)
//   o_full, o_overflow             : FIFO full status, sticky dropped-push flag
//   BID, BRESP, BVALID, BREADY     : AXI B channel toward the master
// All B outputs are flops; BVALID has no combinational path from BREADY.
module axi_slave_b_resp_channel
  import axi_slave_package::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [ID_WIDTH-1:0] int_BID,
  input  Resp_t               int_BRESP,
  input  logic                int_BVALID,
  output logic                o_full,
  output logic                o_overflow,
  output logic [ID_WIDTH-1:0] BID,
  output Resp_t               BRESP,
  output logic                BVALID,
  input  logic                BREADY
);

  b_state_t state_r;
  b_state_t state_s;
  b_resp_t  out_r;
  b_resp_t  head_s;
  b_resp_t  wr_word_s;
  logic     bvalid_r;
  logic     bvalid_s;
  logic     pop_s;
  logic     empty_s;

  assign wr_word_s = '{id: int_BID, resp: int_BRESP};

  axi_slave_resp_fifo #(
    .DEPTH  (DEPTH),
    .word_t (b_resp_t)
  ) u_fifo (
    .clk      (ACLK),
    .rst      (ARESET),
    .push     (int_BVALID),
    .wdata    (wr_word_s),
    .pop      (pop_s),
    .rdata    (head_s),
    .full     (o_full),
    .empty    (empty_s),
    .overflow (o_overflow)
  );

  // Next-state logic: load the output register whenever it is empty or being
  // handed off this cycle, which yields bubble-free back-to-back beats.
  always_comb begin
    state_s  = state_r;
    bvalid_s = bvalid_r;
    pop_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s    = 1'b1;
          bvalid_s = 1'b1;
          state_s  = ST_SEND;
        end else begin
          bvalid_s = 1'b0;
        end
      end
      ST_SEND: begin
        if (BREADY) begin
          if (!empty_s) begin
            pop_s    = 1'b1;
            bvalid_s = 1'b1;
          end else begin
            bvalid_s = 1'b0;
            state_s  = ST_IDLE;
          end
        end else begin
          bvalid_s = 1'b1;
        end
      end
      default: begin
        bvalid_s = 1'b0;
        state_s  = ST_IDLE;
      end
    endcase
  end

  // State, BVALID and output-register flops; reset also flushes a beat on B.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_r  <= ST_IDLE;
      bvalid_r <= 1'b0;
      out_r    <= '{id: {ID_WIDTH{1'b0}}, resp: OKAY};
    end else begin
      state_r  <= state_s;
      bvalid_r <= bvalid_s;
      if (pop_s) begin
        out_r <= head_s;
      end
    end
  end

  assign BVALID = bvalid_r;
  assign BID    = out_r.id;
  assign BRESP  = out_r.resp;

endmodule

// File: doc/axi_slave_b_resp_channel.md
Name: axi_slave_b_resp_channel

Overview:
Consumer end of the slave's internal write-response path. It accepts single-cycle response pulses (ID + Resp_t) from the AW push/pop FSM and buffers them in a small FIFO. It then drives the AXI4 B channel toward the master with a full BVALID/BREADY handshake. It also returns full/overflow status so the AW side can stall before responses are lost.

Parameters:
DEPTH, 8, response FIFO entries; power of two, >= 2
ID_WIDTH, axi_slave_package::ID_WIDTH, AXI ID width (not overridden locally)

Ports:
ACLK  in  1  single clock; all state on rising edge
ARESET  in  1  synchronous reset, active-high
int_BID  in  ID_WIDTH  internal response ID, valid with int_BVALID
int_BRESP  in  Resp_t (2)  internal response code, valid with int_BVALID
int_BVALID  in  1  one-cycle push strobe from AW FSM; no ready/backpressure
o_full  out  1  FIFO count == DEPTH; AW FSM must not pulse int_BVALID while high
o_overflow  out  1  sticky: a push arrived while full and was dropped
BID  out  ID_WIDTH  AXI B channel ID
BRESP  out  Resp_t (2)  AXI B channel response
BVALID  out  1  AXI B channel valid
BREADY  in  1  AXI B channel ready from master

Behaviour:
- Reset (ARESET=1 at an edge): FIFO pointers/count=0; BVALID=0, BID=0, BRESP=OKAY (2'b00); o_full=0; o_overflow=0; FSM=IDLE. Reset mid-transfer flushes all pending responses, including one currently on B.
- FIFO: write and read pointers of $clog2(DEPTH)+1 bits, with the MSB as the wrap bit. Empty when pointers are equal. Full when the index bits are equal and the MSBs differ. Index wraps DEPTH-1 -> 0.
- Push: int_BVALID=1 and not full -> write {int_BID,int_BRESP} at wr_ptr, increment wr_ptr.
- Push while full: data dropped; o_overflow set the next cycle and held until reset. Pointers are unchanged.
- Simultaneous push and pop: both execute. A push while full with a same-cycle pop is accepted (not an overflow). Count is unchanged.
- o_full is registered-state derived (combinational from pointers), with no dependency on int_BVALID.
- Output FSM, 2 states:
  - IDLE: BVALID=0. If FIFO not empty: pop the head into the output register (BID/BRESP), set BVALID=1 -> SEND.
  - SEND: BVALID=1, with BID/BRESP held stable while BREADY=0.
    - On BVALID&&BREADY with FIFO not empty: pop the next entry into the output register and keep BVALID=1, giving back-to-back beats with no bubble.
    - On BVALID&&BREADY with FIFO empty: BVALID=0 -> IDLE.
- Latency: a push strobe in cycle N is written at edge N. It is popped and drives BVALID=1 after edge N+1, i.e. a 2-cycle internal-to-B latency from an empty/IDLE state.
- Sustained throughput is 1 response per cycle while BREADY stays high.
- Ordering: strict FIFO; responses go out in arrival order regardless of ID.
- BVALID never depends combinationally on BREADY. All B outputs are flops.
- Capacity: DEPTH FIFO entries + 1 output register. o_full reflects the FIFO only.

Decomposition:
- axi_slave_package: ID_WIDTH, Resp_t enum (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11), and a b_resp_t packed struct {ID, RESP} used as the FIFO word.
- Sub-module axi_slave_resp_fifo: generic synchronous FIFO parameterised by DEPTH and the word type, with push/pop/full/empty/overflow ports. The top level holds the 2-state FSM and the output register.
- The same FIFO is reused later by the R-side response block.

Test Plan:
- Single response: after reset, pulse int_BVALID with ID=3, RESP=OKAY; BREADY=1 -> BVALID=1 exactly 2 cycles later with BID=3, BRESP=00 for one cycle, then 0.
- Backpressure: push ID=5, SLVERR; hold BREADY=0 for 10 cycles -> BVALID=1, BID=5, BRESP=10 stable all 10 cycles; after BREADY=1, one handshake, then BVALID=0.
- Back-to-back: push IDs 1,2,3,4 on consecutive cycles; BREADY=1 -> BVALID high 4 consecutive cycles, BID sequence 1,2,3,4 with no bubble.
- Full/overflow (DEPTH=8): BREADY=0, push 10 responses with IDs 0-9.
  - ID 0 is held in the output register; IDs 1-8 fill the FIFO, so o_full=1 after the 9th push.
  - The 10th push is dropped and o_overflow=1.
  - Releasing BREADY yields IDs 0-8 in order; ID 9 never appears.
- Simultaneous push/pop at full: FIFO full, BREADY=1, and a push in the same cycle -> no overflow, o_full stays 1, count unchanged, order preserved.
- Reset mid-operation: 3 pending, BVALID=1, assert ARESET for one cycle -> BVALID=0, BID=0, BRESP=00, o_full=0, o_overflow=0. No stale response appears afterwards; a new push after reset is delivered normally.
